// File: rtl/gmii_rx.sv
// GMII receive depacketizer: strips preamble and MAC header, parses the payload header,
// unpacks video/audio words into FIFO write strobes and reports per-frame CRC status.
module gmii_rx #(
   parameter logic [47:0] MY_MAC    = 48'hFFFFFFFFFFFF,
   parameter logic [15:0] ETHERTYPE = 16'h3776,
   parameter logic [15:0] MAX_WORDS = 16'd1280
) (
   input  logic        rx_clk,
   input  logic        rstbtn_n,
   input  logic        rx_dv,
   input  logic        rx_er,
   input  logic [7:0]  rxd,
   input  logic        id,
   output logic [47:0] vid_dout,
   output logic        vid_wr_en,
   input  logic        vid_full,
   output logic [10:0] vid_line,
   output logic [11:0] aud_dout,
   output logic        aud_wr_en,
   input  logic        aud_full,
   output logic [3:0]  ade_num,
   output logic        frame_ok,
   output logic        frame_err,
   output logic [15:0] drop_cnt
);

   typedef enum logic [3:0] {
      S_IDLE, S_PRE, S_DST, S_SRC, S_ETYPE, S_HDR,
      S_VID, S_AUD, S_FCS, S_FEND, S_WAIT, S_DROP
   } state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [15:0] words_q;
   logic [47:0] sr_q;
   logic [31:0] crc_q;
   logic        ovf_q;
   logic        armed_q;
   logic [47:0] vid_dout_q;
   logic        vid_wr_q;
   logic [10:0] vid_line_q;
   logic [11:0] aud_dout_q;
   logic        aud_wr_q;
   logic [3:0]  ade_q;
   logic        ok_q;
   logic        err_q;
   logic [15:0] drop_q;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   function automatic logic [31:0] rev32(input logic [31:0] c);
      logic [31:0] r;
      for (int i = 0; i < 32; i++)
         r[i] = c[31-i];
      return r;
   endfunction

   logic [47:0] sr_d;
   logic [31:0] crc_d;
   logic        in_frame;
   logic        hdr_bad;
   logic        drop_now;
   logic        crc_good;
   logic        end_bad;

   assign sr_d     = {sr_q[39:0], rxd};
   assign crc_d    = crc_byte(crc_q, rxd);
   assign in_frame = (state_q inside {S_DST, S_SRC, S_ETYPE, S_HDR, S_VID, S_AUD, S_FCS});
   assign hdr_bad  = (sr_d[47:40] != 8'h01 && sr_d[47:40] != 8'h02) || (sr_d[32] != id) ||
                     (sr_d[15:0] == 16'd0) || (sr_d[15:0] > MAX_WORDS);
   assign drop_now = (in_frame && (!rx_dv || rx_er)) ||
                     (state_q == S_HDR && cnt_q == 4'd5 && hdr_bad);
   // The register runs reflected, so the residue is compared in its bit-reversed form.
   assign crc_good = (rev32(crc_q) == 32'hC704DD7B);
   assign end_bad  = (state_q == S_FEND) && !rx_dv && (!crc_good || ovf_q);

   always_ff @(posedge rx_clk or negedge rstbtn_n) begin
      if (!rstbtn_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         words_q    <= '0;
         sr_q       <= '0;
         crc_q      <= '0;
         ovf_q      <= 1'b0;
         armed_q    <= 1'b0;
         vid_dout_q <= '0;
         vid_wr_q   <= 1'b0;
         vid_line_q <= '0;
         aud_dout_q <= '0;
         aud_wr_q   <= 1'b0;
         ade_q      <= '0;
         ok_q       <= 1'b0;
         err_q      <= 1'b0;
         drop_q     <= '0;
      end else begin
         vid_wr_q <= 1'b0;
         aud_wr_q <= 1'b0;
         ok_q     <= 1'b0;
         err_q    <= 1'b0;
         // After reset a frame may be in flight; only start decoding once the line went idle.
         if (!rx_dv) armed_q <= 1'b1;
         if (rx_dv) sr_q <= sr_d;
         if (in_frame && rx_dv) crc_q <= crc_d;
         if (drop_now || end_bad) begin
            err_q <= 1'b1;
            if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
         end
         if (drop_now) begin
            state_q <= S_DROP;
         end else begin
            case (state_q)
               S_IDLE: if (rx_dv) begin
                  if (armed_q && rxd == 8'h55) begin
                     state_q <= S_PRE;
                     cnt_q   <= 4'd1;
                  end else begin
                     state_q <= S_WAIT;
                  end
               end
               S_PRE: begin
                  if (!rx_dv) begin
                     state_q <= S_IDLE;
                  end else if (!rx_er && rxd == 8'hD5) begin
                     state_q <= S_DST;
                     cnt_q   <= '0;
                     crc_q   <= '1;
                     ovf_q   <= 1'b0;
                  end else if (!rx_er && rxd == 8'h55 && cnt_q != 4'd15) begin
                     cnt_q <= cnt_q + 4'd1;
                  end else begin
                     state_q <= S_WAIT;
                  end
               end
               S_DST: if (cnt_q == 4'd5) begin
                  cnt_q   <= '0;
                  state_q <= (sr_d == MY_MAC || sr_d == '1) ? S_SRC : S_WAIT;
               end else cnt_q <= cnt_q + 4'd1;
               S_SRC: if (cnt_q == 4'd5) begin
                  cnt_q   <= '0;
                  state_q <= S_ETYPE;
               end else cnt_q <= cnt_q + 4'd1;
               S_ETYPE: if (cnt_q == 4'd1) begin
                  cnt_q   <= '0;
                  state_q <= (sr_d[15:0] == ETHERTYPE) ? S_HDR : S_WAIT;
               end else cnt_q <= cnt_q + 4'd1;
               S_HDR: if (cnt_q == 4'd5) begin
                  cnt_q   <= '0;
                  words_q <= sr_d[15:0];
                  if (sr_d[47:40] == 8'h01) begin
                     state_q    <= S_VID;
                     vid_line_q <= sr_d[26:16];
                  end else begin
                     state_q <= S_AUD;
                     ade_q   <= sr_d[19:16];
                  end
               end else cnt_q <= cnt_q + 4'd1;
               S_VID: if (cnt_q == 4'd5) begin
                  vid_dout_q <= sr_d;
                  vid_wr_q   <= !vid_full;
                  if (vid_full) ovf_q <= 1'b1;
                  cnt_q   <= '0;
                  words_q <= words_q - 16'd1;
                  if (words_q == 16'd1) state_q <= S_FCS;
               end else cnt_q <= cnt_q + 4'd1;
               S_AUD: if (cnt_q == 4'd1) begin
                  aud_dout_q <= sr_d[11:0];
                  aud_wr_q   <= !aud_full;
                  if (aud_full) ovf_q <= 1'b1;
                  cnt_q   <= '0;
                  words_q <= words_q - 16'd1;
                  if (words_q == 16'd1) state_q <= S_FCS;
               end else cnt_q <= cnt_q + 4'd1;
               S_FCS: if (cnt_q == 4'd3) begin
                  cnt_q   <= '0;
                  state_q <= S_FEND;
               end else cnt_q <= cnt_q + 4'd1;
               S_FEND: if (!rx_dv) begin
                  state_q <= S_IDLE;
                  if (crc_good && !ovf_q) ok_q <= 1'b1;
               end
               S_WAIT, S_DROP: if (!rx_dv) state_q <= S_IDLE;
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign vid_dout  = vid_dout_q;
   assign vid_wr_en = vid_wr_q;
   assign vid_line  = vid_line_q;
   assign aud_dout  = aud_dout_q;
   assign aud_wr_en = aud_wr_q;
   assign ade_num   = ade_q;
   assign frame_ok  = ok_q;
   assign frame_err = err_q;
   assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_gmii_rx.sv
// Directed bench for gmii_rx: builds frames with a reference CRC32 and checks strobes and status.
`timescale 1ns/1ps
module tb_gmii_rx;

   localparam logic [47:0] MAC = 48'h020000000001;
   localparam logic [15:0] ET  = 16'h3776;

   logic        rx_clk = 1'b0;
   logic        rstbtn_n = 1'b0;
   logic        rx_dv = 1'b0;
   logic        rx_er = 1'b0;
   logic [7:0]  rxd = 8'h00;
   logic        id = 1'b1;
   logic        vid_full = 1'b0;
   logic        aud_full = 1'b0;
   logic [47:0] vid_dout;
   logic        vid_wr_en;
   logic [10:0] vid_line;
   logic [11:0] aud_dout;
   logic        aud_wr_en;
   logic [3:0]  ade_num;
   logic        frame_ok;
   logic        frame_err;
   logic [15:0] drop_cnt;

   gmii_rx #(.MY_MAC(MAC), .ETHERTYPE(ET), .MAX_WORDS(16'd1280)) dut (
      .rx_clk(rx_clk), .rstbtn_n(rstbtn_n), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd), .id(id),
      .vid_dout(vid_dout), .vid_wr_en(vid_wr_en), .vid_full(vid_full), .vid_line(vid_line),
      .aud_dout(aud_dout), .aud_wr_en(aud_wr_en), .aud_full(aud_full), .ade_num(ade_num),
      .frame_ok(frame_ok), .frame_err(frame_err), .drop_cnt(drop_cnt)
   );

   always #4 rx_clk = ~rx_clk;

   int total = 0;
   int bad = 0;
   int okc = 0;
   int errc = 0;
   int bothc = 0;
   logic [47:0] vq[$];
   logic [11:0] aq[$];
   logic [7:0]  fb[$];

   always @(negedge rx_clk) begin
      if (vid_wr_en) vq.push_back(vid_dout);
      if (aud_wr_en) aq.push_back(aud_dout);
      if (frame_ok) okc++;
      if (frame_err) errc++;
      if (frame_ok && frame_err) bothc++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] vget(input int i);
      return (i < vq.size()) ? {16'd0, vq[i]} : 64'hx;
   endfunction

   function automatic logic [63:0] aget(input int i);
      return (i < aq.size()) ? {52'd0, aq[i]} : 64'hx;
   endfunction

   task automatic clr();
      vq.delete();
      aq.delete();
      okc  = 0;
      errc = 0;
   endtask

   task automatic push(input logic [63:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) fb.push_back(v[8*i +: 8]);
   endtask

   task automatic mk(input logic [47:0] dst, input logic [15:0] et, input logic [7:0] typ,
                     input logic [7:0] flg, input logic [15:0] idx, input logic [15:0] cnt);
      fb.delete();
      push({16'd0, dst}, 6);
      push(64'h001122334455, 6);
      push({48'd0, et}, 2);
      push({56'd0, typ}, 1);
      push({56'd0, flg}, 1);
      push({48'd0, idx}, 2);
      push({48'd0, cnt}, 2);
   endtask

   // FCS is the inverted reflected CRC, sent least significant byte first.
   task automatic add_fcs();
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (fb[i]) begin
         c = c ^ {24'd0, fb[i]};
         repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      c = ~c;
      push({32'd0, c[7:0], c[15:8], c[23:16], c[31:24]}, 4);
   endtask

   task automatic drive(input logic [7:0] b, input logic er, input logic full);
      @(posedge rx_clk); #1;
      rx_dv = 1'b1; rxd = b; rx_er = er; vid_full = full;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge rx_clk); #1;
         rx_dv = 1'b0; rxd = 8'h00; rx_er = 1'b0; vid_full = 1'b0;
      end
   endtask

   task automatic send(input int pre, input int er_at, input int f_lo, input int f_hi);
      for (int i = 0; i < pre; i++) drive(8'h55, 1'b0, 1'b0);
      drive(8'hD5, 1'b0, 1'b0);
      for (int i = 0; i < fb.size(); i++) drive(fb[i], i == er_at, i >= f_lo && i <= f_hi);
      idle(1);
   endtask

   task automatic mk_vid2();
      mk(MAC, ET, 8'h01, 8'h01, 16'd300, 16'd2);
      push(64'h0123456789AB, 6);
      push(64'hCDEF01234567, 6);
      add_fcs();
   endtask

   initial begin
      repeat (3) @(posedge rx_clk);
      #1;
      chk("rst_vid_wr", 64'(vid_wr_en), 64'd0);
      chk("rst_aud_wr", 64'(aud_wr_en), 64'd0);
      chk("rst_ok", 64'(frame_ok), 64'd0);
      chk("rst_err", 64'(frame_err), 64'd0);
      chk("rst_drop", 64'(drop_cnt), 64'd0);
      chk("rst_vdout", 64'(vid_dout), 64'd0);
      chk("rst_line", 64'(vid_line), 64'd0);
      chk("rst_ade", 64'(ade_num), 64'd0);
      chk("rst_adout", 64'(aud_dout), 64'd0);
      rstbtn_n = 1'b1;
      idle(3);

      clr(); mk_vid2(); send(7, -1, -1, -1); idle(10);
      chk("vid_n", 64'(vq.size()), 64'd2);
      chk("vid_w0", vget(0), 64'h0123456789AB);
      chk("vid_w1", vget(1), 64'hCDEF01234567);
      chk("vid_line", 64'(vid_line), 64'd300);
      chk("vid_ok", 64'(okc), 64'd1);
      chk("vid_err", 64'(errc), 64'd0);
      chk("vid_drop", 64'(drop_cnt), 64'd0);

      clr();
      mk(48'hFFFFFFFFFFFF, ET, 8'h02, 8'h01, 16'd3, 16'd3);
      push(64'h0ABC, 2); push(64'h0123, 2); push(64'h0FFF, 2);
      add_fcs(); send(7, -1, -1, -1); idle(10);
      chk("aud_n", 64'(aq.size()), 64'd3);
      chk("aud_s0", aget(0), 64'hABC);
      chk("aud_s1", aget(1), 64'h123);
      chk("aud_s2", aget(2), 64'hFFF);
      chk("aud_ade", 64'(ade_num), 64'd3);
      chk("aud_ok", 64'(okc), 64'd1);
      chk("aud_line_kept", 64'(vid_line), 64'd300);

      clr(); mk_vid2(); fb[20] = fb[20] ^ 8'h01; send(7, -1, -1, -1); idle(10);
      chk("flip_n", 64'(vq.size()), 64'd2);
      chk("flip_w0", vget(0), 64'h0023456789AB);
      chk("flip_ok", 64'(okc), 64'd0);
      chk("flip_err", 64'(errc), 64'd1);
      chk("flip_drop", 64'(drop_cnt), 64'd1);

      clr(); mk_vid2(); send(7, 30, -1, -1); idle(10);
      chk("er_n", 64'(vq.size()), 64'd1);
      chk("er_w0", vget(0), 64'h0123456789AB);
      chk("er_err", 64'(errc), 64'd1);
      chk("er_ok", 64'(okc), 64'd0);
      chk("er_drop", 64'(drop_cnt), 64'd2);

      clr();
      mk(48'h020000000002, ET, 8'h01, 8'h01, 16'd1, 16'd1);
      push(64'h1, 6); add_fcs(); send(7, -1, -1, -1); idle(10);
      mk(MAC, 16'h0800, 8'h01, 8'h01, 16'd1, 16'd1);
      push(64'h1, 6); add_fcs(); send(7, -1, -1, -1); idle(10);
      chk("mac_et_n", 64'(vq.size()), 64'd0);
      chk("mac_et_ok", 64'(okc), 64'd0);
      chk("mac_et_err", 64'(errc), 64'd0);
      chk("mac_et_drop", 64'(drop_cnt), 64'd2);

      // Second word stalled by a full FIFO, then a good frame after a 12-cycle gap.
      clr();
      mk(MAC, ET, 8'h01, 8'h01, 16'd7, 16'd4);
      push(64'h111111111111, 6); push(64'h222222222222, 6);
      push(64'h333333333333, 6); push(64'h444444444444, 6);
      add_fcs(); send(7, -1, 26, 31); idle(11);
      mk(MAC, ET, 8'h01, 8'h01, 16'd5, 16'd1);
      push(64'h5555AAAA5555, 6); add_fcs(); send(7, -1, -1, -1); idle(10);
      chk("full_n", 64'(vq.size()), 64'd4);
      chk("full_w0", vget(0), 64'h111111111111);
      chk("full_w1", vget(1), 64'h333333333333);
      chk("full_w2", vget(2), 64'h444444444444);
      chk("b2b_w", vget(3), 64'h5555AAAA5555);
      chk("full_err", 64'(errc), 64'd1);
      chk("b2b_ok", 64'(okc), 64'd1);
      chk("full_drop", 64'(drop_cnt), 64'd3);
      chk("b2b_line", 64'(vid_line), 64'd5);

      clr();
      mk(MAC, ET, 8'h01, 8'h00, 16'd1, 16'd1); push(64'h1, 6); add_fcs(); send(7, -1, -1, -1); idle(4);
      mk(MAC, ET, 8'h01, 8'h01, 16'd1, 16'd0); add_fcs(); send(7, -1, -1, -1); idle(4);
      mk(MAC, ET, 8'h01, 8'h01, 16'd1, 16'd1281); push(64'h1, 6); add_fcs(); send(7, -1, -1, -1); idle(4);
      mk(MAC, ET, 8'h03, 8'h01, 16'd1, 16'd1); push(64'h1, 6); add_fcs(); send(7, -1, -1, -1); idle(4);
      chk("hdr_n", 64'(vq.size()), 64'd0);
      chk("hdr_err", 64'(errc), 64'd4);
      chk("hdr_ok", 64'(okc), 64'd0);
      chk("hdr_drop", 64'(drop_cnt), 64'd7);

      clr(); mk_vid2(); send(15, -1, -1, -1); idle(10);
      chk("pre15_ok", 64'(okc), 64'd1);
      clr(); mk_vid2(); send(16, -1, -1, -1); idle(10);
      chk("pre16_ok", 64'(okc), 64'd0);
      chk("pre16_err", 64'(errc), 64'd0);
      chk("pre16_n", 64'(vq.size()), 64'd0);

      clr(); mk_vid2();
      for (int i = 0; i < 7; i++) drive(8'h55, 1'b0, 1'b0);
      drive(8'hD5, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) drive(fb[i], 1'b0, 1'b0);
      @(posedge rx_clk); #1;
      rstbtn_n = 1'b0; rxd = fb[10];
      #2;
      chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
      chk("mid_rst_line", 64'(vid_line), 64'd0);
      @(posedge rx_clk); #1;
      rstbtn_n = 1'b1; rxd = fb[11];
      for (int i = 0; i < 7; i++) drive(8'h55, 1'b0, 1'b0);
      drive(8'hD5, 1'b0, 1'b0);
      for (int i = 0; i < fb.size(); i++) drive(fb[i], 1'b0, 1'b0);
      idle(10);
      chk("mid_ok", 64'(okc), 64'd0);
      chk("mid_err", 64'(errc), 64'd0);
      chk("mid_n", 64'(vq.size()), 64'd0);
      chk("mid_drop", 64'(drop_cnt), 64'd0);

      clr(); mk_vid2(); send(7, -1, -1, -1); idle(10);
      chk("rec_ok", 64'(okc), 64'd1);
      chk("rec_n", 64'(vq.size()), 64'd2);
      chk("ok_err_excl", 64'(bothc), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gmii_rx.md
Name: gmii_rx

Overview:
- GMII receive-side depacketizer; the counterpart of gmii_tx.
- Takes Ethernet frames from the PHY and strips preamble, MAC header and ethertype, then parses the team payload header.
- Unpacks 48-bit video words and 12-bit audio samples into write strobes for the downstream video and audio FIFOs.
- Checks the frame CRC32 and signals commit or discard per frame; sits between the PHY RX pins and the HDMI output FIFOs.

Parameters:
- MY_MAC, 48'hFFFFFFFFFFFF, accepted destination MAC; broadcast is always accepted as well.
- ETHERTYPE, 16'h3776, required ethertype; any other value drops the frame.
- MAX_WORDS, 16'd1280, largest legal payload word count.

Ports:
- rx_clk in 1: GMII RX clock, 125 MHz; the only clock.
- rstbtn_n in 1: asynchronous active-low reset.
- rx_dv in 1: GMII receive data valid.
- rx_er in 1: GMII receive error.
- rxd in 8: GMII receive data.
- id in 1: stream id to accept; compared with payload header bit 0.
- vid_dout out 48: video word.
- vid_wr_en out 1: video FIFO write strobe.
- vid_full in 1: video FIFO full.
- vid_line out 11: line number of the current video packet.
- aud_dout out 12: audio sample.
- aud_wr_en out 1: audio FIFO write strobe.
- aud_full in 1: audio FIFO full.
- ade_num out 4: audio period count from the last audio packet.
- frame_ok out 1: one-cycle pulse when a frame ends with a good CRC.
- frame_err out 1: one-cycle pulse when an accepted frame is discarded.
- drop_cnt out 16: count of discarded frames; saturates at 16'hFFFF.

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Frame layout after SFD, big-endian:
  - DST 6, SRC 6, ETYPE 2.
  - TYPE 1: 0x01 video, 0x02 audio.
  - FLAGS 1: bit0 = id.
  - IDX 2: video = line number in low 11 bits; audio = ade_num in low 4 bits.
  - CNT 2: word count.
  - Payload: video 6 bytes/word; audio 2 bytes/sample, right-aligned 12 bits.
  - FCS 4.
- State machine (one byte per cycle while rx_dv=1):
  - IDLE -> PRE on rx_dv=1 and rxd=0x55.
  - PRE -> DST on rxd=0xD5. In PRE, a byte other than 0x55/0xD5 -> WAIT. More than 15 preamble bytes -> WAIT.
  - DST -> SRC after 6 bytes; DST must equal MY_MAC or broadcast, else -> WAIT.
  - SRC -> ETYPE after 6 bytes; ETYPE mismatch -> WAIT.
  - HDR: 6 bytes. Invalid TYPE, FLAGS[0]!=id, CNT=0 or CNT>MAX_WORDS -> DROP.
  - HDR -> VID or AUD. Leave after CNT words -> FCS (4 bytes) -> IDLE.
  - WAIT: silent drop, no pulses or counters; -> IDLE when rx_dv=0.
  - DROP: -> IDLE when rx_dv=0. Pulse frame_err once and increment drop_cnt.
- Data path:
  - Video word assembled MSB first: first byte -> vid_dout[47:40].
  - vid_wr_en pulses 1 cycle, the cycle after the 6th byte of each word.
  - vid_line is latched at the end of HDR and is stable for the whole payload.
  - Audio sample = {byte0[3:0], byte1}; aud_wr_en pulses the cycle after byte1.
  - ade_num is updated at the end of HDR for audio packets only.
- CRC32:
  - IEEE 802.3, reflected, init 0xFFFFFFFF.
  - Computed over DST through FCS inclusive.
  - Good when the residue equals 0xC704DD7B, evaluated the cycle after rx_dv falls.
  - Good -> frame_ok; bad -> frame_err and drop_cnt+1.
  - Payload words already written are not retracted; the downstream uses frame_err to discard the line.
- Errors in the accepted states (DST through FCS):
  - rx_er=1, or rx_dv falling before FCS completes -> DROP.
  - After the last FCS byte, bytes with rx_dv still 1 are ignored; the CRC is evaluated at the rx_dv fall.
- FIFO full:
  - A write while the target FIFO full=1 is suppressed.
  - Frame is marked overflow; at the end frame_err pulses instead of frame_ok regardless of CRC.
- frame_ok and frame_err are never asserted in the same cycle.
- Back-to-back frames: a minimum 1-cycle rx_dv=0 gap is required; after FCS the block returns to IDLE in time for a 12-cycle IFG.
- Reset mid-frame: immediate return to IDLE; outputs cleared; the rest of the frame is ignored until rx_dv=0.

Test Plan:
- Video frame with MY_MAC dst, id=1, line=11'd300, CNT=2, words 0x0123456789AB and 0xCDEF01234567, good FCS -> two vid_wr_en pulses with those values, vid_line=300, one frame_ok.
- Audio frame, ade_num=4'd3, CNT=3, samples 0x0ABC/0x0123/0x0FFF -> aud_dout ABC, 123, FFF; ade_num=3; frame_ok.
- Same video frame with one payload bit flipped -> words written, frame_err pulse, drop_cnt=1, no frame_ok.
- rx_er asserted on byte 30 -> frame_err, no further writes, drop_cnt increments.
- Wrong dst MAC or ethertype 0x0800 -> no writes, no pulses, drop_cnt unchanged.
- vid_full=1 during word 2 of CNT=4 -> 3 writes only; frame_err; then a back-to-back good frame after a 12-cycle IFG -> frame_ok.
